// File: rtl/mdu_iter_unit_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// opcode constants, FSM state encoding and operand sign helpers.
package mdu_iter_unit_pkg;

    localparam int XLEN  = 32;
    localparam int CNT_W = $clog2(XLEN);

    localparam logic [2:0] F3_MUL    = 3'd0;
    localparam logic [2:0] F3_MULH   = 3'd1;
    localparam logic [2:0] F3_MULHSU = 3'd2;
    localparam logic [2:0] F3_MULHU  = 3'd3;
    localparam logic [2:0] F3_DIV    = 3'd4;
    localparam logic [2:0] F3_DIVU   = 3'd5;
    localparam logic [2:0] F3_REM    = 3'd6;
    localparam logic [2:0] F3_REMU   = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic op_a_signed(input logic [2:0] f3);
        return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_MULHSU) ||
               (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    function automatic logic op_b_signed(input logic [2:0] f3);
        return (f3 == F3_MUL) || (f3 == F3_MULH) ||
               (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] v, input logic neg);
        return neg ? (~v + {{(XLEN-1){1'b0}}, 1'b1}) : v;
    endfunction

endpackage

// File: rtl/mdu_iter_step.sv
// One combinational iteration: LSB-first shift-add for multiply,
// restoring shift-subtract for divide (remainder in acc, quotient in opr).
module mdu_iter_step
    import mdu_iter_unit_pkg::*;
#(
    parameter int W = XLEN
) (
    input  logic         div_i,
    input  logic [W-1:0] acc_i,
    input  logic [W-1:0] opr_i,
    input  logic [W-1:0] arg_i,
    output logic [W-1:0] acc_o,
    output logic [W-1:0] opr_o
);

    logic [W:0] sum_s;
    logic [W:0] diff_s;

    assign sum_s  = {1'b0, acc_i} + {1'b0, arg_i};
    assign diff_s = {acc_i, opr_i[W-1]} - {1'b0, arg_i};

    // Next accumulator/operand pair for the selected mode
    always_comb begin
        acc_o = acc_i;
        opr_o = opr_i;
        if (div_i) begin
            // A borrow out means the shifted remainder is below the divisor: restore
            if (!diff_s[W]) begin
                acc_o = diff_s[W-1:0];
                opr_o = {opr_i[W-2:0], 1'b1};
            end else begin
                acc_o = {acc_i[W-2:0], opr_i[W-1]};
                opr_o = {opr_i[W-2:0], 1'b0};
            end
        end else begin
            if (opr_i[0]) begin
                acc_o = sum_s[W:1];
                opr_o = {sum_s[0], opr_i[W-1:1]};
            end else begin
                acc_o = {1'b0, acc_i[W-1:1]};
                opr_o = {acc_i[0], opr_i[W-1:1]};
            end
        end
    end

endmodule

// File: rtl/mdu_iter_unit.sv
// Iterative RV32M multiply/divide unit: one step per cycle on operand
// magnitudes, sign fixup on the last step, registered write-back port.
module mdu_iter_unit
    import mdu_iter_unit_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [4:0]      rd_in,
    output logic            busy,
    output logic            done,
    output logic            we,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out
);

    localparam logic [XLEN-1:0]  ALL_ONES = {XLEN{1'b1}};
    localparam logic [XLEN-1:0]  ZERO     = {XLEN{1'b0}};
    localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

    state_e           state_q;
    logic [CNT_W-1:0] count_q;
    logic [2:0]       op_q;
    logic             sign_q;
    logic [XLEN-1:0]  acc_q;
    logic [XLEN-1:0]  opr_q;
    logic [XLEN-1:0]  arg_q;
    logic [XLEN-1:0]  result_q;
    logic [4:0]       rd_q;
    logic             busy_q;
    logic             done_q;

    logic [XLEN-1:0]   acc_d;
    logic [XLEN-1:0]   opr_d;
    logic [XLEN-1:0]   result_d;
    logic              a_neg_s;
    logic              b_neg_s;
    logic [XLEN-1:0]   a_mag_s;
    logic [XLEN-1:0]   b_mag_s;
    logic              sign_s;
    logic              div_zero_s;
    logic              div_ovf_s;
    logic [XLEN-1:0]   special_s;
    logic [2*XLEN-1:0] prod_s;
    logic [2*XLEN-1:0] prod_fix_s;

    mdu_iter_step #(.W(XLEN)) u_step (
        .div_i (op_q[2]),
        .acc_i (acc_q),
        .opr_i (opr_q),
        .arg_i (arg_q),
        .acc_o (acc_d),
        .opr_o (opr_d)
    );

    // Operand magnitudes, result sign and early-exit detection at accept
    always_comb begin
        a_neg_s    = op_a_signed(funct3) & rs1_data[XLEN-1];
        b_neg_s    = op_b_signed(funct3) & rs2_data[XLEN-1];
        a_mag_s    = neg_if(rs1_data, a_neg_s);
        b_mag_s    = neg_if(rs2_data, b_neg_s);
        div_zero_s = funct3[2] && (rs2_data == ZERO);
        div_ovf_s  = ((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
                     (rs1_data == INT_MIN) && (rs2_data == ALL_ONES);
        case (funct3)
            F3_MUL, F3_MULH, F3_DIV: sign_s = a_neg_s ^ b_neg_s;
            F3_MULHSU, F3_REM:       sign_s = a_neg_s;
            default:                 sign_s = 1'b0;
        endcase
        // funct3[1] distinguishes REM/REMU from DIV/DIVU
        if (div_zero_s) begin
            special_s = funct3[1] ? rs1_data : ALL_ONES;
        end else begin
            special_s = funct3[1] ? ZERO : INT_MIN;
        end
    end

    // Final-step result; the high product half needs the full-width negation
    always_comb begin
        prod_s     = {acc_d, opr_d};
        prod_fix_s = sign_q ? (~prod_s + {{(2*XLEN-1){1'b0}}, 1'b1}) : prod_s;
        case (op_q)
            F3_MUL:                       result_d = prod_fix_s[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: result_d = prod_fix_s[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:              result_d = neg_if(opr_d, sign_q);
            F3_REM, F3_REMU:              result_d = neg_if(acc_d, sign_q);
            default:                      result_d = ZERO;
        endcase
    end

    // Control FSM with datapath registers and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            count_q  <= {CNT_W{1'b0}};
            op_q     <= 3'd0;
            sign_q   <= 1'b0;
            acc_q    <= ZERO;
            opr_q    <= ZERO;
            arg_q    <= ZERO;
            result_q <= ZERO;
            rd_q     <= 5'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        op_q    <= funct3;
                        rd_q    <= rd_in;
                        sign_q  <= sign_s;
                        count_q <= {CNT_W{1'b0}};
                        busy_q  <= 1'b1;
                        acc_q   <= ZERO;
                        // Divide shifts the dividend out of opr; multiply shifts the multiplier
                        if (funct3[2]) begin
                            opr_q <= a_mag_s;
                            arg_q <= b_mag_s;
                        end else begin
                            opr_q <= b_mag_s;
                            arg_q <= a_mag_s;
                        end
                        if (div_zero_s || div_ovf_s) begin
                            result_q <= special_s;
                            done_q   <= 1'b1;
                            state_q  <= ST_DONE;
                        end else begin
                            state_q  <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    acc_q   <= acc_d;
                    opr_q   <= opr_d;
                    count_q <= count_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (count_q == CNT_LAST) begin
                        result_q <= result_d;
                        done_q   <= 1'b1;
                        state_q  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign we     = done_q;
    assign result = result_q;
    assign rd_out = rd_q;

endmodule

// File: tb/tb_mdu_iter_unit.sv
// Directed self-checking bench for mdu_iter_unit with hand-computed results.
module tb_mdu_iter_unit;
    import mdu_iter_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] rs1_data = 32'd0;
    logic [31:0] rs2_data = 32'd0;
    logic [4:0]  rd_in = 5'd0;
    logic        busy;
    logic        done;
    logic        we;
    logic [31:0] result;
    logic [4:0]  rd_out;

    int checks = 0;
    int errors = 0;

    mdu_iter_unit dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .funct3   (funct3),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .rd_in    (rd_in),
        .busy     (busy),
        .done     (done),
        .we       (we),
        .result   (result),
        .rd_out   (rd_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called just after a falling edge; returns just after a falling edge with the unit idle.
    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd,
                          input logic [31:0] exp, input int exp_lat);
        int lat;
        start = 1'b1; funct3 = f3; rs1_data = a; rs2_data = b; rd_in = rd;
        @(posedge clk);
        #1;
        start = 1'b0; funct3 = ~f3; rs1_data = $urandom; rs2_data = $urandom; rd_in = ~rd;
        lat = 0;
        @(negedge clk);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
        while (done !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
        chk({tag, "_we"}, {31'd0, we}, 32'd1);
        chk({tag, "_res"}, result, exp);
        chk({tag, "_rd"}, {27'd0, rd_out}, {27'd0, rd});
        @(negedge clk);
        chk({tag, "_pulse"}, {30'd0, done, we}, 32'd0);
        chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
        chk({tag, "_hold"}, result, exp);
    endtask

    initial begin
        int ndone;
        int dcyc;
        logic [31:0] dres;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {30'd0, done, we}, 32'd0);
        chk("rst_res", result, 32'd0);
        chk("rst_rd", {27'd0, rd_out}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op("mul_5x4",    F3_MUL,    32'h00000005, 32'h00000004, 5'd7,  32'h00000014, 32);
        run_op("mulh_m1",    F3_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1,  32'h00000000, 32);
        run_op("mulhu_m1",   F3_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2,  32'hFFFFFFFE, 32);
        run_op("mulhsu_m1",  F3_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3,  32'hFFFFFFFF, 32);
        run_op("mul_m1",     F3_MUL,    32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4,  32'h00000001, 32);
        run_op("mulh_min2",  F3_MULH,   32'h80000000, 32'h00000002, 5'd5,  32'hFFFFFFFF, 32);
        run_op("div_m7_2",   F3_DIV,    32'hFFFFFFF9, 32'h00000002, 5'd8,  32'hFFFFFFFD, 32);
        run_op("rem_m7_2",   F3_REM,    32'hFFFFFFF9, 32'h00000002, 5'd9,  32'hFFFFFFFF, 32);
        run_op("divu_100_7", F3_DIVU,   32'h00000064, 32'h00000007, 5'd10, 32'h0000000E, 32);
        run_op("remu_100_7", F3_REMU,   32'h00000064, 32'h00000007, 5'd11, 32'h00000002, 32);
        run_op("divu_by0",   F3_DIVU,   32'h12345678, 32'h00000000, 5'd12, 32'hFFFFFFFF, 0);
        run_op("remu_by0",   F3_REMU,   32'h12345678, 32'h00000000, 5'd13, 32'h12345678, 0);
        run_op("div_ovf",    F3_DIV,    32'h80000000, 32'hFFFFFFFF, 5'd14, 32'h80000000, 0);
        run_op("rem_ovf",    F3_REM,    32'h80000000, 32'hFFFFFFFF, 5'd15, 32'h00000000, 0);

        // Extra start pulses during a MUL must be ignored
        start = 1'b1; funct3 = F3_MUL; rs1_data = 32'h00000005; rs2_data = 32'h00000004; rd_in = 5'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        ndone = 0; dcyc = 0; dres = 32'd0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                ndone++;
                dcyc = c;
                dres = result;
            end
            start = (c == 5) || (c == 20);
            funct3 = F3_DIVU; rs1_data = 32'h0000DEAD; rs2_data = 32'h00000003; rd_in = 5'd3;
        end
        start = 1'b0;
        chk("ign_ndone", ndone, 32'd1);
        chk("ign_cycle", dcyc, 32'd33);
        chk("ign_res", dres, 32'h00000014);
        chk("ign_rd", {27'd0, rd_out}, 32'd7);

        // Reset in the middle of a DIV aborts it without a done pulse
        start = 1'b1; funct3 = F3_DIVU; rs1_data = 32'h00000064; rs2_data = 32'h00000007; rd_in = 5'd20;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_res", result, 32'd0);
        chk("arst_done", {30'd0, done, we}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        chk("arst_nodone", ndone, 32'd0);
        run_op("mul_after_rst", F3_MUL, 32'h00000006, 32'h00000007, 5'd21, 32'h0000002A, 32);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
